// File: rtl/lvl_pkg.sv
// Shared constants, types and level/code conversion helpers for the level sensor encoder.
package lvl_pkg;

    localparam logic [2:0] LVL_CODE_INVALID = 3'd7;
    localparam logic [2:0] LVL_MAX          = 3'd4;

    // Per-tank channel state: HOLD drives a valid code, ERR drives the invalid code.
    typedef enum logic {
        StHold,
        StErr
    } tank_state_e;

    // Result of a thermometer decode.
    typedef struct packed {
        logic       valid;
        logic [2:0] level;
    } lvl_dec_t;

    // Thermometer pattern (logical, 1 = wet) to level; anything else is a bubble.
    function automatic lvl_dec_t therm_decode(input logic [3:0] therm);
        lvl_dec_t dec;
        dec.valid = 1'b1;
        dec.level = 3'd0;
        case (therm)
            4'b0000: dec.level = 3'd0;
            4'b0001: dec.level = 3'd1;
            4'b0011: dec.level = 3'd2;
            4'b0111: dec.level = 3'd3;
            4'b1111: dec.level = 3'd4;
            default: dec.valid = 1'b0;
        endcase
        return dec;
    endfunction

    // Level to output code; inverted codes count down from LVL_MAX.
    function automatic logic [2:0] lvl_encode(input logic [2:0] level, input logic inverted);
        return inverted ? (LVL_MAX - level) : level;
    endfunction

endpackage

// File: rtl/lvl_tank_channel.sv
// One tank: decode, jump check, bad-sample persistence and registered output code.
module lvl_tank_channel
    import lvl_pkg::*;
#(
    parameter int unsigned INVALID_SAMPLES = 3,
    parameter int unsigned MAX_STEP        = 1,
    parameter bit          OUT_INVERTED    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] therm,
    output logic [2:0] code,
    output logic       err
);

    localparam int unsigned CW = $clog2(INVALID_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(INVALID_SAMPLES);
    localparam logic [2:0]    STEP    = 3'(MAX_STEP);

    tank_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    level_q, level_d;
    logic [2:0]    code_q, code_d;

    lvl_dec_t      dec;
    logic [2:0]    diff;
    logic [CW-1:0] cnt_inc;
    logic          jump_bad;
    logic          bad;

    assign dec     = therm_decode(therm);
    // Unsigned |decoded - held| in 3 bits.
    assign diff    = (dec.level > level_q) ? (dec.level - level_q) : (level_q - dec.level);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + 1'b1);

    // State, persistence counter, held level and output code registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StErr;
            cnt_q   <= '0;
            level_q <= 3'd0;
            code_q  <= LVL_CODE_INVALID;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            code_q  <= code_d;
        end
    end

    // Next-state: evaluate one sample per tick, hold everything otherwise.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        code_d   = code_q;
        jump_bad = 1'b0;

        // Jump check only applies while a valid level is being held.
        unique case (state_q)
            StHold:  jump_bad = (diff > STEP);
            StErr:   jump_bad = 1'b0;
            default: jump_bad = 1'b0;
        endcase

        bad = !dec.valid || jump_bad;

        if (tick) begin
            if (!bad) begin
                state_d = StHold;
                cnt_d   = '0;
                level_d = dec.level;
                code_d  = lvl_encode(dec.level, OUT_INVERTED);
            end else begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_MAX) begin
                    state_d = StErr;
                    code_d  = LVL_CODE_INVALID;
                end
            end
        end
    end

    assign code = code_q;
    assign err  = (state_q == StErr);

endmodule

// File: rtl/level_sensor_encoder.sv
// Float-switch front end: synchronise both tanks, sample on a slow tick, emit level codes.
module level_sensor_encoder
    import lvl_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned SAMPLE_MS       = 5,
    parameter int unsigned INVALID_SAMPLES = 3,
    parameter int unsigned MAX_STEP        = 1,
    parameter bit          SW_ACTIVE_LOW   = 1'b1,
    parameter bit          OUT_INVERTED    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_inf,
    input  logic [3:0] sw_sup,
    output logic [2:0] lvl_inf_code,
    output logic [2:0] lvl_sup_code,
    output logic       inf_err,
    output logic       sup_err,
    output logic       sample_stb
);

    localparam int unsigned SAMPLE_TICKS = (CLK_HZ / 1000) * SAMPLE_MS;
    localparam int unsigned PW           = $clog2(SAMPLE_TICKS + 1);
    localparam logic [PW-1:0] CNT_LAST   = PW'(SAMPLE_TICKS - 1);
    // Physical pin level of a dry switch, so reset reads as logically dry.
    localparam logic [7:0] SYNC_DRY      = SW_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0]    sync1_q, sync2_q;
    logic [7:0]    wet;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic          stb_q;

    // Two-flop synchroniser for all eight switch pins ({sup, inf}).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= SYNC_DRY;
            sync2_q <= SYNC_DRY;
        end else begin
            sync1_q <= {sw_sup, sw_inf};
            sync2_q <= sync1_q;
        end
    end

    assign wet = SW_ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Prescaler next count: wrap after the tick cycle.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    // Prescaler and strobe registers; strobe marks the cycle new codes are visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            stb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            stb_q <= tick;
        end
    end

    assign sample_stb = stb_q;

    lvl_tank_channel #(
        .INVALID_SAMPLES (INVALID_SAMPLES),
        .MAX_STEP        (MAX_STEP),
        .OUT_INVERTED    (OUT_INVERTED)
    ) u_inf (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .therm (wet[3:0]),
        .code  (lvl_inf_code),
        .err   (inf_err)
    );

    lvl_tank_channel #(
        .INVALID_SAMPLES (INVALID_SAMPLES),
        .MAX_STEP        (MAX_STEP),
        .OUT_INVERTED    (OUT_INVERTED)
    ) u_sup (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .therm (wet[7:4]),
        .code  (lvl_sup_code),
        .err   (sup_err)
    );

endmodule

// File: tb/tb_level_sensor_encoder.sv
// Bench for level_sensor_encoder: directed plan plus randomized samples against a level model.
module tb_level_sensor_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw_inf = 4'b1111;
    logic [3:0] sw_sup = 4'b1100;
    logic [2:0] lvl_inf_code, lvl_sup_code;
    logic       inf_err, sup_err, sample_stb;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per tank (0 = inf, 1 = sup).
    int m_code[2];
    int m_cnt[2];
    int m_lvl[2];

    logic [3:0] cur_inf = 4'b0000;  // logical (1 = wet)
    logic [3:0] cur_sup = 4'b0011;

    level_sensor_encoder #(
        .CLK_HZ          (1000),
        .SAMPLE_MS       (4),
        .INVALID_SAMPLES (3),
        .MAX_STEP        (1),
        .SW_ACTIVE_LOW   (1'b1),
        .OUT_INVERTED    (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_inf       (sw_inf),
        .sw_sup       (sw_sup),
        .lvl_inf_code (lvl_inf_code),
        .lvl_sup_code (lvl_sup_code),
        .inf_err      (inf_err),
        .sup_err      (sup_err),
        .sample_stb   (sample_stb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model reset: invalid code, cleared counter.
    task automatic model_reset();
        for (int t = 0; t < 2; t++) begin
            m_code[t] = 7;
            m_cnt[t]  = 0;
            m_lvl[t]  = 0;
        end
    endtask

    // One sample of one tank, from the level rules expressed arithmetically.
    task automatic model_tank(input int t, input logic [3:0] pat);
        int  lvl;
        int  diff;
        bit  valid;
        bit  bad;
        lvl   = $countones(pat);
        valid = (int'(pat) == ((1 << lvl) - 1));
        diff  = (lvl > m_lvl[t]) ? lvl - m_lvl[t] : m_lvl[t] - lvl;
        bad   = !valid || (m_code[t] != 7 && diff > 1);
        if (!bad) begin
            m_cnt[t]  = 0;
            m_lvl[t]  = lvl;
            m_code[t] = 4 - lvl;
        end else begin
            if (m_cnt[t] < 3) m_cnt[t] = m_cnt[t] + 1;
            if (m_cnt[t] == 3) m_code[t] = 7;
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, "_inf_code"}, 32'(lvl_inf_code), 32'(m_code[0]));
        check({tag, "_sup_code"}, 32'(lvl_sup_code), 32'(m_code[1]));
        check({tag, "_inf_err"},  32'(inf_err), 32'(m_code[0] == 7));
        check({tag, "_sup_err"},  32'(sup_err), 32'(m_code[1] == 7));
    endtask

    // Count rising edges until sample_stb is seen at a falling edge; bounded.
    task automatic wait_stb(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!sample_stb && cycles < 20);
        if (!sample_stb) check("stb_timeout", 32'(cycles), 32'd4);
    endtask

    // Called at the falling edge of a strobe cycle: apply new logical patterns, check next sample.
    task automatic run_sample(input logic [3:0] inf_l, input logic [3:0] sup_l, input string tag);
        int cyc;
        cur_inf = inf_l;
        cur_sup = sup_l;
        sw_inf  = ~inf_l;
        sw_sup  = ~sup_l;
        wait_stb(cyc);
        check({tag, "_period"}, 32'(cyc), 32'd4);
        model_tank(0, inf_l);
        model_tank(1, sup_l);
        compare_outputs(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [3:0] ramp[5];
        logic [3:0] pi, ps;
        ramp[0] = 4'b0000; ramp[1] = 4'b0001; ramp[2] = 4'b0011;
        ramp[3] = 4'b0111; ramp[4] = 4'b1111;
        model_reset();

        // Reset with steady inputs.
        repeat (3) @(negedge clk);
        check("rst_inf_code", 32'(lvl_inf_code), 32'd7);
        check("rst_sup_code", 32'(lvl_sup_code), 32'd7);
        check("rst_inf_err",  32'(inf_err), 32'd1);
        check("rst_sup_err",  32'(sup_err), 32'd1);
        check("rst_stb",      32'(sample_stb), 32'd0);
        rst_n = 1'b1;
        wait_stb(cyc);
        check("first_stb_delay", 32'(cyc), 32'd4);
        check("first_inf_code", 32'(lvl_inf_code), 32'd4);
        check("first_sup_code", 32'(lvl_sup_code), 32'd2);
        model_tank(0, cur_inf);
        model_tank(1, cur_sup);
        compare_outputs("first");

        // Ramp lower tank 0 -> 4, two samples (8 cycles) per step.
        for (int i = 0; i < 5; i++) begin
            run_sample(ramp[i], 4'b0011, "ramp");
            run_sample(ramp[i], 4'b0011, "ramp_hold");
        end

        // Transient bubble on upper tank.
        run_sample(cur_inf, 4'b0101, "bubble_t");
        run_sample(cur_inf, 4'b0101, "bubble_t");
        check("bubble_t_sup_held", 32'(lvl_sup_code), 32'd2);
        run_sample(cur_inf, 4'b0011, "bubble_t_end");

        // Persistent bubble then recovery.
        run_sample(cur_inf, 4'b0101, "bubble_p");
        run_sample(cur_inf, 4'b0101, "bubble_p");
        run_sample(cur_inf, 4'b0101, "bubble_p3");
        check("bubble_p_sup_invalid", 32'(lvl_sup_code), 32'd7);
        run_sample(cur_inf, 4'b0011, "bubble_p_end");
        check("bubble_p_sup_recover", 32'(lvl_sup_code), 32'd2);

        // Jump rejection: held level 1, then level 4 pattern.
        run_sample(cur_inf, 4'b0001, "jump_pre");
        run_sample(cur_inf, 4'b1111, "jump1");
        run_sample(cur_inf, 4'b1111, "jump2");
        check("jump_held", 32'(lvl_sup_code), 32'd3);
        run_sample(cur_inf, 4'b1111, "jump3");
        check("jump_invalid", 32'(lvl_sup_code), 32'd7);
        run_sample(cur_inf, 4'b1111, "jump4");
        check("jump_accept", 32'(lvl_sup_code), 32'd0);

        // Mid-operation reset, asserted between clock edges.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_inf_code", 32'(lvl_inf_code), 32'd7);
        check("mid_rst_sup_code", 32'(lvl_sup_code), 32'd7);
        check("mid_rst_inf_err",  32'(inf_err), 32'd1);
        check("mid_rst_sup_err",  32'(sup_err), 32'd1);
        check("mid_rst_stb",      32'(sample_stb), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_stb(cyc);
        check("mid_rst_stb_delay", 32'(cyc), 32'd4);
        model_tank(0, cur_inf);
        model_tank(1, cur_sup);
        compare_outputs("mid_rst_first");

        // Randomized samples: mostly valid levels (with jumps), some arbitrary patterns.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) pi = 4'($urandom_range(0, 15));
            else pi = ramp[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) ps = 4'($urandom_range(0, 15));
            else ps = ramp[$urandom_range(0, 4)];
            // Repeat patterns sometimes so persistence and recovery both get exercised.
            repeat ($urandom_range(1, 3)) run_sample(pi, ps, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/level_sensor_encoder.md
Name: level_sensor_encoder

Overview:
- Upstream front end of pump_controller: converts raw float-switch thermometer inputs from the lower and upper tanks into the 3-bit level codes that pump_controller consumes on lvl_inf_in / lvl_sup_in.
- Synchronises the switch inputs and samples them on a slow periodic tick.
- Rejects bubble patterns and implausible jumps, and reports the invalid code 7 only after the error persists.
- Output codes are active-low by default, so pump_controller runs with INVERT_LEVEL_CODE=1.

Parameters:
- CLK_HZ, 50_000_000, clock frequency in Hz.
- SAMPLE_MS, 5, sampling period in ms. SAMPLE_TICKS = (CLK_HZ/1000)*SAMPLE_MS, which must be >= 1.
- INVALID_SAMPLES, 3, number of consecutive bad samples before the output goes to 7. Must be >= 1.
- MAX_STEP, 1, largest accepted level change between consecutive samples. A value of 4 disables the jump check.
- SW_ACTIVE_LOW, 1, switch pins read 0 when wet.
- OUT_INVERTED, 1, output code = 4 - level when 1, otherwise code = level.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sw_inf  input  4  lower-tank float switches; bit0 = 25%, bit3 = 100%; asynchronous to clk
- sw_sup  input  4  upper-tank float switches, same bit order as sw_inf
- lvl_inf_code  output  3  lower-tank level code (0..4, or 7 = invalid)
- lvl_sup_code  output  3  upper-tank level code (0..4, or 7 = invalid)
- inf_err  output  1  high while lvl_inf_code == 7
- sup_err  output  1  high while lvl_sup_code == 7
- sample_stb  output  1  one-cycle pulse marking the cycle in which updated outputs first appear

Behaviour:
- Reset (asynchronous, immediate):
  - Both codes = 7; inf_err = sup_err = 1; sample_stb = 0.
  - Prescaler = 0; invalid counters = 0; synchroniser flops = logical dry (0).
  - Reset asserted mid-operation forces these values without waiting for a clock edge.
- Synchroniser:
  - Each switch bit passes through a 2-FF synchroniser.
  - The bit is inverted after synchronisation when SW_ACTIVE_LOW = 1, so that logical 1 = wet.
- Prescaler:
  - Counts 0..SAMPLE_TICKS-1 and wraps.
  - tick = (count == SAMPLE_TICKS-1), combinational.
  - All per-tank evaluation happens on the clock edge that ends a tick cycle.
  - sample_stb is registered; it is high for the single cycle after that edge, which is the cycle in which the new codes are visible.
- Decode (per tank, on tick):
  - Valid patterns: 0000, 0001, 0011, 0111, 1111 map to levels 0, 1, 2, 3, 4.
  - Any other pattern is a bubble and counts as a bad sample.
  - Jump check: if the held output is not 7 and the decoded level differs from the held level by more than MAX_STEP, the sample counts as bad.
  - When the held output is 7, any valid pattern is accepted and no jump check is applied.
- Persistence (per tank):
  - Good sample: invalid counter = 0, output = encoded level, err = 0.
  - Bad sample: invalid counter increments and saturates at INVALID_SAMPLES.
    - When the counter reaches INVALID_SAMPLES on this tick, output = 7 and err = 1.
    - Otherwise the previous output is held unchanged.
- Per-tank state: HOLD (output valid) and ERR (output 7).
  - HOLD → ERR after INVALID_SAMPLES consecutive bad samples.
  - ERR → HOLD on the first valid pattern.
- Tank independence: the two tanks are fully independent; a bubble on one tank never affects the other.
- Latency:
  - Switch edge to output change: 2 sync cycles plus up to SAMPLE_TICKS cycles, plus 1 register stage.
  - Worst case SAMPLE_TICKS + 3 cycles.
- Width rules:
  - Level difference is computed as an unsigned absolute value in 3 bits.
  - The prescaler is sized with $clog2(SAMPLE_TICKS+1).

Decomposition:
- Shared package lvl_pkg holds:
  - LVL_CODE_INVALID = 3'd7
  - LVL_MAX = 3'd4
  - the thermometer-to-level decode function
  - the level-to-output-code encode function (honours OUT_INVERTED)
- The per-tank decode, jump check, persistence counter and output register form one sub-module: lvl_tank_channel.
  - It is instantiated twice; the prescaler and synchronisers stay in the top level.

Test Plan:
Benches use CLK_HZ=1000, SAMPLE_MS=4 (SAMPLE_TICKS=4), INVALID_SAMPLES=3, MAX_STEP=1, SW_ACTIVE_LOW=1, OUT_INVERTED=1.
- Reset then steady inputs: hold rst_n=0 for 3 cycles with sw_inf=4'b1111 (dry), sw_sup=4'b1100 (two wet) -> during reset both codes = 7 and both errs = 1. At the first sample_stb: lvl_inf_code=4 (level 0), lvl_sup_code=2 (level 2), both errs = 0.
- Ramp: step sw_inf through the patterns for levels 0→1→2→3→4, one step per 8 cycles -> lvl_inf_code goes 4, 3, 2, 1, 0. Each change appears no more than 7 cycles after the input edge.
- Transient bubble: drive sw_sup to the pattern for logical 0101 for 2 samples, then back to a valid level -> the output holds its previous value, sup_err stays 0, and lvl_inf_code is unaffected.
- Persistent bubble: hold the logical 0101 pattern for 3 samples -> lvl_sup_code=7 and sup_err=1 on the 3rd sample_stb. Restoring logical 0011 -> lvl_sup_code=2 and sup_err=0 on the next sample_stb.
- Jump rejection: with the held level at 1, apply a valid level-4 pattern -> the output stays at code 3 for 2 samples, then becomes 7 on the 3rd sample, then code 0 (level 4) on the 4th sample.
- Mid-operation reset: assert rst_n=0 in the middle of a sample period -> codes go to 7 within the same cycle, with no clock edge needed. After release, the first sample_stb arrives exactly 4 cycles later.
